// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - registered N-channel field mux with manual select and masked auto-scan
module mux_scan_sel #(
  parameter int W     = 2,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  x,
  input  logic [SELW-1:0] sel,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    ch_mask,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_ch,
  output logic            y_valid,
  output logic            sel_err
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} op_e;

  op_e              op;
  logic [W-1:0]     fld [N];
  logic [SELW-1:0]  next_ch;
  logic             found;
  logic [W-1:0]     y_d, y_q;
  logic [SELW-1:0]  y_ch_d, y_ch_q, ch_d, ch_q;
  logic             y_valid_d, y_valid_q, sel_err_d, sel_err_q;
  logic [CNTW-1:0]  cnt_d, cnt_q;

  always_comb begin
    for (int k = 0; k < N; k++) fld[k] = x[k*W +: W];

    // First enabled channel strictly after ch, wrapping; ch itself is the last candidate.
    next_ch = ch_q;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && ch_mask[SELW'((int'(ch_q) + k) % N)]) begin
        next_ch = SELW'((int'(ch_q) + k) % N);
        found   = 1'b1;
      end
    end

    if (!en || (mode && ch_mask == '0)) op = IDLE;
    else if (!mode)                     op = MANUAL;
    else                                op = SCAN;

    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    sel_err_d = sel_err_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;

    case (op)
      MANUAL: begin
        if (int'(sel) < N) begin
          y_d       = fld[sel];
          y_ch_d    = sel;
          y_valid_d = 1'b1;
          sel_err_d = 1'b0;
          ch_d      = sel;
          cnt_d     = '0;
        end else begin
          sel_err_d = 1'b1;
        end
      end
      SCAN: begin
        if (ch_mask[ch_q]) begin
          y_d       = fld[ch_q];
          y_ch_d    = ch_q;
          y_valid_d = 1'b1;
          sel_err_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            ch_d  = next_ch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          ch_d  = next_ch;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
      ch_q      <= '0;
      cnt_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised, registered N-channel, W-bit-per-channel field multiplexer.
- Successor to the combinational multi-channel selector.
- Manual mode: selects a channel from `sel`.
- Auto-scan mode: round-robins over the enabled channels in `ch_mask`, dwelling DWELL cycles on each.
- Sits between packed multi-channel sample buses and single-channel consumers such as display drivers and serial formatters.

Parameters:
- W, 2, bits per channel field.
- N, 4, number of channels (2..16; need not be a power of two).
- SELW, 2, width of channel index; must satisfy 2^SELW >= N.
- DWELL, 4, cycles spent on each channel in auto-scan (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- x  in  N*W  packed channel data; channel k occupies x[k*W +: W].
- sel  in  SELW  manual channel index.
- en  in  1  block enable.
- mode  in  1  0 = manual, 1 = auto-scan.
- ch_mask  in  N  per-channel enable for auto-scan (ignored in manual mode).
- y  out  W  registered selected field.
- y_ch  out  SELW  index of the channel that y was taken from.
- y_valid  out  1  y holds a fresh sample from the current cycle.
- sel_err  out  1  manual sel >= N on the last enabled edge.

Behaviour:
- Reset (async, rst=1): y=0, y_ch=0, y_valid=0, sel_err=0; internal ch=0, cnt=0. Outputs clear immediately, not at the next edge. Release takes effect at the first clk edge with rst=0.
- Latency: 1 clock. y and y_ch reflect x and the channel index sampled at the preceding rising edge.
- States:
  - IDLE: en=0, or mode=1 with ch_mask all zero.
  - MANUAL: en=1, mode=0.
  - SCAN: en=1, mode=1, ch_mask nonzero.
  - State is re-evaluated every edge.
- IDLE: y and y_ch hold; y_valid<=0; sel_err holds; ch and cnt hold.
- MANUAL, sel<N: y<=x[sel*W +: W]; y_ch<=sel; y_valid<=1; sel_err<=0; ch<=sel; cnt<=0.
- MANUAL, sel>=N: y and y_ch hold; y_valid<=0; sel_err<=1; ch and cnt hold.
- SCAN, ch_mask[ch]=1:
  - y<=x[ch*W +: W]; y_ch<=ch (pre-edge ch); y_valid<=1; sel_err<=0.
  - If cnt==DWELL-1: cnt<=0 and ch<=next enabled channel. Otherwise cnt<=cnt+1.
- SCAN, ch_mask[ch]=0 (entered SCAN on a masked channel, or mask changed): y and y_ch hold; y_valid<=0; ch<=next enabled channel; cnt<=0. Costs exactly one invalid cycle.
- Next enabled channel: (ch+k) mod N for the smallest k in 1..N with that mask bit set. Wraps N-1 to 0. With a single enabled channel equal to ch, ch stays.
- Mode switch:
  - MANUAL to SCAN: scan starts from the current ch with cnt unchanged (0 from MANUAL).
  - SCAN to MANUAL: sel takes effect on the same edge; cnt cleared.
- en deassert mid-scan: ch and cnt freeze. On re-enable, the scan resumes from the same point with the same remaining dwell.
- ch and cnt are internal. cnt is wide enough for DWELL-1.
- No combinational path from any input to any output.

Test Plan:
1. Manual select. W=2, N=4, x=8'b10_11_01_00 (ch0=00, ch1=01, ch2=11, ch3=10), en=1, mode=0.
   - sel=1, one edge -> y=01, y_ch=1, y_valid=1.
   - sel=2, next edge -> y=11, y_ch=2.
2. Enable hold. After scenario 1, en=0 for 3 edges with x changed to 8'hFF -> y=11 held, y_valid=0. en=1 with sel=2 -> y=11 from the new x, y_valid=1.
3. Auto-scan full mask. DWELL=2, mode=1, ch_mask=4'b1111, start ch=0.
   - y_ch per edge: 0,0,1,1,2,2,3,3,0,0.
   - y matches each field; y_valid=1 throughout.
4. Sparse and empty mask.
   - ch_mask=4'b0101 -> y_ch sequence 0,0,2,2,0,0.
   - Switch to ch_mask=4'b0100 while on ch0 -> one cycle y_valid=0, then y_ch=2 steadily.
   - ch_mask=0 -> y_valid=0, y holds.
5. Illegal select. N=3, SELW=2, mode=0, sel=3 -> sel_err=1, y_valid=0, y unchanged. sel=1 -> sel_err=0, y=ch1 field.
6. Reset mid-scan. Assert rst between edges while y_ch=2 -> y, y_ch, y_valid, sel_err go 0 before the next edge. Release -> scan restarts at ch0 with a full DWELL.
